// File: rtl/program_loader_if.sv
// Bus between a program source / CPU wrapper (master) and the ternary program loader (slave).
// Trits are 2-bit codes: 00 = -1, 01 = 0, 10 = +1, 11 = illegal.
interface program_loader_if #(
   parameter int WORD_SIZE     = 9,
   parameter int MEM_ADDR_SIZE = 9
);
   logic                         start;
   logic                         in_valid;
   logic [1:0]                   in_trit;
   logic                         in_last;
   logic                         in_ready;
   logic [2*MEM_ADDR_SIZE-1:0]   ld_mem_address;
   logic [2*WORD_SIZE-1:0]       ld_mem_write_data;
   logic                         ld_mem_write;
   logic                         cpu_execute;
   logic                         cpu_halted;
   logic                         busy;
   logic                         done;
   logic                         error;

   modport master (
      output start, in_valid, in_trit, in_last, cpu_halted,
      input  in_ready, ld_mem_address, ld_mem_write_data, ld_mem_write,
             cpu_execute, busy, done, error
   );

   modport slave (
      input  start, in_valid, in_trit, in_last, cpu_halted,
      output in_ready, ld_mem_address, ld_mem_write_data, ld_mem_write,
             cpu_execute, busy, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Streams trits into words, writes them to sequential balanced-ternary addresses,
// then kicks the CPU and waits for it to halt.
module program_loader #(
   parameter int WORD_SIZE     = 9,
   parameter int MEM_ADDR_SIZE = 9
) (
   input  logic              clock,
   input  logic              reset,
   program_loader_if.slave   bus
);

   localparam int DW    = 2 * WORD_SIZE;
   localparam int AW    = 2 * MEM_ADDR_SIZE;
   localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

   localparam logic [1:0] T_NEG  = 2'b00;
   localparam logic [1:0] T_ZERO = 2'b01;
   localparam logic [1:0] T_POS  = 2'b10;
   localparam logic [1:0] T_BAD  = 2'b11;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_SIZE - 1);
   localparam logic [AW-1:0]    ADDR_ZERO = {MEM_ADDR_SIZE{T_ZERO}};
   localparam logic [DW-1:0]    WORD_ZERO = {WORD_SIZE{T_ZERO}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_EXEC, S_WAIT_HALT, S_DONE, S_ERROR
   } state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DW-1:0]     shift_q;
   logic              wrapped_q;
   logic              last_q;
   logic              in_ready_q;
   logic              ld_mem_write_q;
   logic              cpu_execute_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic [AW-1:0]     ld_mem_address_q;
   logic [DW-1:0]     ld_mem_write_data_q;

   logic              accept;
   logic              last_trit;
   logic [DW-1:0]     word_d;
   logic [AW-1:0]     addr_inc_d;

   // Balanced-ternary +1: a +1 trit rolls to -1 and carries, anything else absorbs the carry.
   function automatic logic [AW-1:0] bt_inc(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      logic          carry;
      r     = a;
      carry = 1'b1;
      for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
         if (carry) begin
            if (a[2*i +: 2] == T_POS) begin
               r[2*i +: 2] = T_NEG;
            end else begin
               r[2*i +: 2] = (a[2*i +: 2] == T_NEG) ? T_ZERO : T_POS;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign accept     = in_ready_q & bus.in_valid;
   assign last_trit  = (idx_q == LAST_IDX);
   assign addr_inc_d = bt_inc(addr_q);

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      word_d = shift_q;
      for (int k = 0; k < WORD_SIZE; k++) begin
         if (idx_q == IDX_W'(k)) word_d[2*k +: 2] = bus.in_trit;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (bus.start) state_d = S_LOAD;
         S_LOAD: begin
            if (accept) begin
               if (bus.in_trit == T_BAD)             state_d = S_ERROR;
               else if (bus.in_last && !last_trit)   state_d = S_ERROR;
               else if (last_trit)                   state_d = wrapped_q ? S_ERROR : S_WRITE;
            end
         end
         S_WRITE:     state_d = last_q ? S_EXEC : S_LOAD;
         S_EXEC:      state_d = S_WAIT_HALT;
         S_WAIT_HALT: if (bus.cpu_halted) state_d = S_DONE;
         default:     state_d = S_IDLE;
      endcase
   end

   // NOTE: outputs are decoded from state_d and registered, so each one is glitch-free
   // and lines up exactly with the state it belongs to.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q             <= S_IDLE;
         addr_q              <= ADDR_ZERO;
         idx_q               <= '0;
         shift_q             <= WORD_ZERO;
         wrapped_q           <= 1'b0;
         last_q              <= 1'b0;
         in_ready_q          <= 1'b0;
         ld_mem_write_q      <= 1'b0;
         cpu_execute_q       <= 1'b0;
         busy_q              <= 1'b0;
         done_q              <= 1'b0;
         error_q             <= 1'b0;
         ld_mem_address_q    <= ADDR_ZERO;
         ld_mem_write_data_q <= WORD_ZERO;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= (state_d == S_LOAD);
         busy_q         <= (state_d == S_LOAD) || (state_d == S_WRITE);
         ld_mem_write_q <= (state_d == S_WRITE);
         cpu_execute_q  <= (state_d == S_EXEC);
         done_q         <= (state_d == S_DONE);
         error_q        <= (state_d == S_ERROR);

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  addr_q    <= ADDR_ZERO;
                  idx_q     <= '0;
                  shift_q   <= WORD_ZERO;
                  wrapped_q <= 1'b0;
                  last_q    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  shift_q <= word_d;
                  idx_q   <= last_trit ? '0 : idx_q + IDX_W'(1);
                  last_q  <= bus.in_last;
                  if (state_d == S_WRITE) begin
                     ld_mem_address_q    <= addr_q;
                     ld_mem_write_data_q <= word_d;
                  end
               end
            end
            S_WRITE: begin
               addr_q <= addr_inc_d;
               // Landing back on zero means every address has now been used once.
               if (addr_inc_d == ADDR_ZERO) wrapped_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.ld_mem_address    = ld_mem_address_q;
   assign bus.ld_mem_write_data = ld_mem_write_data_q;
   assign bus.ld_mem_write      = ld_mem_write_q;
   assign bus.cpu_execute       = cpu_execute_q;
   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.error             = error_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 9, giving trits per memory word.
REQ-002 The block SHALL have parameter MEM_ADDR_SIZE, default 9, giving trits per memory address.
REQ-003 Each trit SHALL use 2 bits: 2'b00 = -1, 2'b01 = 0, 2'b10 = +1, 2'b11 = illegal.
REQ-004 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle load request.
- in_valid  in  1  in_trit is valid.
- in_trit  in  2  one program trit.
- in_last  in  1  marks the final trit of the final word.
- in_ready  out  1  loader accepts a trit this cycle.
- ld_mem_address  out  2*MEM_ADDR_SIZE  write address to program memory.
- ld_mem_write_data  out  2*WORD_SIZE  assembled word.
- ld_mem_write  out  1  memory write strobe.
- cpu_execute  out  1  one-cycle pulse to the CPU execute input.
- cpu_halted  in  1  CPU halted flag.
- busy  out  1  loader owns the memory bus.
- done  out  1  program ran to halt.
- error  out  1  load aborted.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, WRITE, EXEC, WAIT_HALT, DONE and ERROR.
REQ-006 start SHALL be honoured only in IDLE, DONE or ERROR, and SHALL move the FSM to LOAD with the address and trit index cleared; start in any other state SHALL be ignored.
REQ-007 On entering LOAD from start:
- address = all trits 0 (2'b01).
- trit index = 0.
- shift word = all 0 trits.
- wrapped flag cleared.
- done and error cleared.
REQ-008 in_ready SHALL be 1 only in LOAD; a trit is accepted on any rising edge with in_valid and in_ready both high.
REQ-009 Trit assembly SHALL be LSB-first: the k-th accepted trit of a word is stored at bits [2k+1:2k].
REQ-010 Accepting trit index WORD_SIZE-1 SHALL move the FSM to WRITE on the same edge and reset the trit index to 0.
REQ-011 WRITE SHALL last exactly one cycle:
- ld_mem_write = 1.
- ld_mem_address = current address.
- ld_mem_write_data = assembled word.
- On exit, the address SHALL increment by 1 in balanced ternary (+1 trit becomes -1 with carry).
- On exit, the next state is EXEC if in_last accompanied the final trit, else LOAD.
REQ-012 The address SHALL wrap from all +1 to all -1 with no error; when an increment yields all 0, the wrapped flag SHALL be set.
REQ-013 Completing a word while the wrapped flag is set (more than 3^MEM_ADDR_SIZE words) SHALL enter ERROR without asserting ld_mem_write.
REQ-014 An accepted trit of 2'b11 SHALL enter ERROR on that edge, and that word SHALL not be written.
REQ-015 in_last accepted at a trit index other than WORD_SIZE-1 SHALL enter ERROR, and that word SHALL not be written.
REQ-016 EXEC SHALL last one cycle with cpu_execute = 1, then go to WAIT_HALT.
REQ-017 cpu_halted SHALL be sampled only in WAIT_HALT; when it is 1, the FSM SHALL go to DONE.
REQ-018 busy SHALL be 1 in LOAD and WRITE only.
REQ-019 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR; both SHALL hold until the next start or reset.
REQ-020 Outside WRITE, ld_mem_write SHALL be 0; ld_mem_address and ld_mem_write_data SHALL hold their last values.
REQ-021 in_valid while in_ready = 0 SHALL have no effect, and the trit SHALL not be consumed.
REQ-022 Latency from acceptance of the final trit of a word to the ld_mem_write pulse SHALL be 1 cycle.

Reset
REQ-023 When reset is low, the block SHALL asynchronously force:
- state = IDLE.
- in_ready, ld_mem_write, cpu_execute, busy, done, error = 0.
- ld_mem_address = all 2'b01; ld_mem_write_data = all 2'b01.
- internal counters and flags cleared.
REQ-024 Reset asserted mid-LOAD, WRITE or WAIT_HALT SHALL abandon the operation, with no further writes or execute pulse after release.

Verification (WORD_SIZE=3, MEM_ADDR_SIZE=2)
REQ-025 Single-word load: start, then trits 10,01,00 with in_last on the third -> one cycle later, ld_mem_write=1, address=0101, data=000110; next cycle cpu_execute=1; cpu_halted=1 -> done=1.
REQ-026 Address increment and wrap: load 6 words -> write addresses 0,+1,(+1,-1),(+1,0),(+1,+1),(-1,-1), i.e. 0101, 0110, 1000, 1001, 1010, 0000.
REQ-027 Overflow: stream 10 words -> 9 writes occur, the 10th word completes -> error=1, no 10th ld_mem_write, cpu_execute never pulses.
REQ-028 Illegal trit and early in_last:
- 2'b11 as trit 1 -> error=1 on the next cycle, no write.
- Separately, in_last on trit 0 -> error=1, no write.
REQ-029 Backpressure and reset:
- in_valid held high through WRITE -> no trit lost or duplicated.
- reset pulsed low during the second word -> all outputs at reset values.
- A new start reloads from address 0101.
